// File: rtl/pwm_pkg.sv
// Shared widths, constants and helpers for the PWM output peripheral.
package pwm_pkg;

  localparam int unsigned PWM_CNT_W = 8;
  localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
  localparam int unsigned NUM_PINS = 16;

  typedef logic [PWM_CNT_W-1:0] pwm_cnt_t;
  typedef logic [NUM_PINS-1:0]  pin_vec_t;

  typedef enum logic [1:0] {
    PinLow,
    PinHigh,
    PinPwm
  } pin_mode_e;

  // Output enable dominates; mode select only matters for enabled pins.
  function automatic pin_mode_e pin_mode(logic en_out, logic en_pwm);
    if (!en_out) begin
      return PinLow;
    end else if (!en_pwm) begin
      return PinHigh;
    end
    return PinPwm;
  endfunction

  // Full-scale duty is special-cased so 0xFF gives a constant high with no wrap blip.
  function automatic logic pwm_level(pwm_cnt_t cnt, pwm_cnt_t duty);
    return (duty == DUTY_FULL) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Free-running clock divider: one-clk tick every PRESCALE_DIV system clocks.
module pwm_prescaler #(
  parameter int unsigned PRESCALE_DIV = 3000,
  parameter int unsigned PRESC_W      = 12
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [PRESC_W-1:0] LastCount = PRESC_W'(PRESCALE_DIV - 1);

  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;

  always_comb begin
    tick        = (presc_cnt_q == LastCount);
    presc_cnt_d = tick ? '0 : presc_cnt_q + PRESC_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt_q <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-pin output block: per-pin forced low/high or shared 8-bit PWM, with the
// duty cycle double-buffered so it only changes at a period boundary.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int unsigned PRESCALE_DIV = 3000,
  parameter int unsigned PRESC_W      = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          en_reg_out_7_0,
  input  logic [7:0]          en_reg_out_15_8,
  input  logic [7:0]          en_reg_pwm_7_0,
  input  logic [7:0]          en_reg_pwm_15_8,
  input  logic [7:0]          pwm_duty_cycle,
  output logic [NUM_PINS-1:0] out,
  output logic                period_start
);

  localparam pwm_cnt_t CntMax = '1;

  pin_vec_t en_out, en_pwm;
  logic     tick, boundary, level;

  pwm_cnt_t pwm_cnt_q, pwm_cnt_d;
  pwm_cnt_t duty_shadow_q, duty_shadow_d;
  pin_vec_t out_q, out_d;
  logic     period_start_q, period_start_d;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  pwm_prescaler #(
    .PRESCALE_DIV (PRESCALE_DIV),
    .PRESC_W      (PRESC_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_comb begin
    boundary       = tick && (pwm_cnt_q == CntMax);
    pwm_cnt_d      = tick ? pwm_cnt_q + PWM_CNT_W'(1) : pwm_cnt_q;
    // A write landing on the boundary clk itself is the one captured.
    duty_shadow_d  = boundary ? pwm_duty_cycle : duty_shadow_q;
    period_start_d = boundary;
    level          = pwm_level(pwm_cnt_q, duty_shadow_q);
  end

  always_comb begin
    out_d = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      unique case (pin_mode(en_out[i], en_pwm[i]))
        PinLow:  out_d[i] = 1'b0;
        PinHigh: out_d[i] = 1'b1;
        PinPwm:  out_d[i] = level;
        default: out_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q      <= '0;
      duty_shadow_q  <= '0;
      out_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      pwm_cnt_q      <= pwm_cnt_d;
      duty_shadow_q  <= duty_shadow_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral with PRESCALE_DIV=4 (period = 1024 clks).
module tb_pwm_peripheral;

  localparam int DIV    = 4;
  localparam int PERIOD = 256 * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  always #5 clk = ~clk;

  pwm_peripheral #(
    .PRESCALE_DIV (DIV),
    .PRESC_W      (12)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .out             (out),
    .period_start    (period_start)
  );

  typedef struct packed {
    logic        ps;
    logic [15:0] pins;
  } exp_t;

  exp_t       sb[$];
  int         m_k;       // clk edges since reset release
  logic [7:0] m_shadow;
  int         n_checks = 0;
  int         n_fail   = 0;

  // Reference model: one clk edge, expected registered outputs pushed to the scoreboard.
  task automatic advance();
    logic [7:0] cnt_b;
    logic       bnd, lvl;
    exp_t       e;
    @(posedge clk);
    cnt_b = 8'((m_k / DIV) % 256);
    bnd   = ((m_k + 1) % PERIOD) == 0;
    if (m_shadow == 8'hFF) lvl = 1'b1;
    else                   lvl = (cnt_b < m_shadow);
    e.pins = {en_reg_out_15_8, en_reg_out_7_0}
           & (~{en_reg_pwm_15_8, en_reg_pwm_7_0} | {16{lvl}});
    e.ps   = bnd;
    sb.push_back(e);
    m_k++;
    if (bnd) m_shadow = pwm_duty_cycle;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst      = 1'b0;
    m_k      = 0;
    m_shadow = 8'h00;
    sb.delete();
  endtask

  task automatic test_reset();
    exp_t e;
    int   pulses, first_k;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out !== 16'h0000) begin
      n_fail++; $display("FAIL reset_out got=%h want=0000", out);
    end
    n_checks++;
    if (period_start !== 1'b0) begin
      n_fail++; $display("FAIL reset_ps got=%b want=0", period_start);
    end
    @(negedge clk);
    rst = 1'b0; m_k = 0; m_shadow = 8'h00; sb.delete();
    pulses = 0; first_k = -1;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      advance();
      e = sb.pop_front();
      n_checks++;
      if (out !== e.pins || period_start !== e.ps) begin
        n_fail++;
        $display("FAIL sb_reset k=%0d got out=%h ps=%b want out=%h ps=%b",
                 m_k, out, period_start, e.pins, e.ps);
      end
      if (period_start === 1'b1) begin
        pulses++;
        if (first_k < 0) first_k = m_k;
      end
    end
    n_checks++;
    if (pulses != 2) begin
      n_fail++; $display("FAIL ps_count got=%0d want=2", pulses);
    end
    n_checks++;
    if (first_k != PERIOD) begin
      n_fail++; $display("FAIL ps_first got=%0d want=%0d", first_k, PERIOD);
    end
  endtask

  task automatic test_enable();
    exp_t        e;
    logic [15:0] want [4] = '{16'h0001, 16'h8000, 16'h00FF, 16'h0000};
    logic [15:0] eo   [4] = '{16'h0001, 16'h8000, 16'hFFFF, 16'h0000};
    logic [15:0] ep   [4] = '{16'h0000, 16'h0000, 16'hFF00, 16'hFFFF};
    for (int t = 0; t < 4; t++) begin
      {en_reg_out_15_8, en_reg_out_7_0} = eo[t];
      {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep[t];
      advance();
      e = sb.pop_front();
      n_checks++;
      if (out !== e.pins || period_start !== e.ps) begin
        n_fail++;
        $display("FAIL sb_enable t=%0d got out=%h ps=%b want out=%h ps=%b",
                 t, out, period_start, e.pins, e.ps);
      end
      n_checks++;
      if (out !== want[t]) begin
        n_fail++; $display("FAIL enable_next_clk t=%0d got=%h want=%h", t, out, want[t]);
      end
    end
  endtask

  task automatic test_duty_half();
    exp_t e;
    int   hi, first_hi, last_hi;
    apply_reset();
    pwm_duty_cycle = 8'h80;
    {en_reg_out_15_8, en_reg_out_7_0} = 16'h00FF;
    {en_reg_pwm_15_8, en_reg_pwm_7_0} = 16'h00FF;
    for (int p = 0; p < 3; p++) begin
      hi = 0; first_hi = -1; last_hi = -1;
      for (int i = 0; i < PERIOD; i++) begin
        advance();
        e = sb.pop_front();
        n_checks++;
        if (out !== e.pins || period_start !== e.ps) begin
          n_fail++;
          $display("FAIL sb_half k=%0d got out=%h ps=%b want out=%h ps=%b",
                   m_k, out, period_start, e.pins, e.ps);
        end
        if (out[7:0] === 8'hFF) begin
          hi++;
          if (first_hi < 0) first_hi = i;
          last_hi = i;
        end
      end
      n_checks++;
      if (hi != ((p == 0) ? 0 : 512)) begin
        n_fail++; $display("FAIL half_high p=%0d got=%0d want=%0d", p, hi, (p == 0) ? 0 : 512);
      end
      if (p != 0) begin
        n_checks++;
        if (first_hi != 0 || last_hi != 511) begin
          n_fail++; $display("FAIL half_window p=%0d got=%0d..%0d want=0..511", p, first_hi, last_hi);
        end
      end
    end
  endtask

  task automatic test_duty_extremes();
    exp_t       e;
    int         cnt;
    logic [7:0] duties [2] = '{8'h00, 8'hFF};
    for (int d = 0; d < 2; d++) begin
      pwm_duty_cycle = duties[d];
      cnt = 0;
      for (int i = 0; i < 4 * PERIOD; i++) begin
        advance();
        e = sb.pop_front();
        n_checks++;
        if (out !== e.pins || period_start !== e.ps) begin
          n_fail++;
          $display("FAIL sb_extreme k=%0d got out=%h ps=%b want out=%h ps=%b",
                   m_k, out, period_start, e.pins, e.ps);
        end
        // First period still runs the previous duty.
        if (i >= PERIOD && out[0] !== duties[d][0]) cnt++;
      end
      n_checks++;
      if (cnt != 0) begin
        n_fail++; $display("FAIL extreme_const duty=%h got=%0d off-level clks want=0", duties[d], cnt);
      end
    end
  endtask

  task automatic test_mid_period();
    exp_t e;
    int   hi;
    int   want_hi [5] = '{1024, 256, 768, 128, 192};
    pwm_duty_cycle = 8'h40;
    for (int p = 0; p < 5; p++) begin
      hi = 0;
      for (int i = 0; i < PERIOD; i++) begin
        if (p == 1 && i == 100)        pwm_duty_cycle = 8'hC0;
        if (p == 2 && i == 50)         pwm_duty_cycle = 8'h10;
        if (p == 2 && i == 300)        pwm_duty_cycle = 8'h20;
        if (p == 3 && i == PERIOD - 1) pwm_duty_cycle = 8'h30;
        advance();
        e = sb.pop_front();
        n_checks++;
        if (out !== e.pins || period_start !== e.ps) begin
          n_fail++;
          $display("FAIL sb_mid k=%0d got out=%h ps=%b want out=%h ps=%b",
                   m_k, out, period_start, e.pins, e.ps);
        end
        if (out[0] === 1'b1) hi++;
      end
      n_checks++;
      if (hi != want_hi[p]) begin
        n_fail++; $display("FAIL mid_high p=%0d got=%0d want=%0d", p, hi, want_hi[p]);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    int   hi, pulses;
    pwm_duty_cycle = 8'h80;
    for (int i = 0; i < PERIOD + 100; i++) begin
      advance();
      e = sb.pop_front();
      n_checks++;
      if (out !== e.pins || period_start !== e.ps) begin
        n_fail++;
        $display("FAIL sb_prerst k=%0d got out=%h ps=%b want out=%h ps=%b",
                 m_k, out, period_start, e.pins, e.ps);
      end
    end
    n_checks++;
    if (out !== 16'h00FF) begin
      n_fail++; $display("FAIL prerst_high got=%h want=00FF", out);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (out !== 16'h0000 || period_start !== 1'b0) begin
      n_fail++; $display("FAIL async_rst got out=%h ps=%b want out=0000 ps=0", out, period_start);
    end
    @(negedge clk);
    rst = 1'b0; m_k = 0; m_shadow = 8'h00; sb.delete();
    for (int p = 0; p < 2; p++) begin
      hi = 0; pulses = 0;
      for (int i = 0; i < PERIOD; i++) begin
        advance();
        e = sb.pop_front();
        n_checks++;
        if (out !== e.pins || period_start !== e.ps) begin
          n_fail++;
          $display("FAIL sb_postrst k=%0d got out=%h ps=%b want out=%h ps=%b",
                   m_k, out, period_start, e.pins, e.ps);
        end
        if (out[0] === 1'b1) hi++;
        if (period_start === 1'b1) pulses++;
      end
      n_checks++;
      if (hi != ((p == 0) ? 0 : 512) || pulses != 1) begin
        n_fail++;
        $display("FAIL postrst_period p=%0d got hi=%0d pulses=%0d want hi=%0d pulses=1",
                 p, hi, pulses, (p == 0) ? 0 : 512);
      end
    end
  endtask

  initial begin
    rst             = 1'b1;
    en_reg_out_7_0  = 8'h00;
    en_reg_out_15_8 = 8'h00;
    en_reg_pwm_7_0  = 8'h00;
    en_reg_pwm_15_8 = 8'h00;
    pwm_duty_cycle  = 8'h00;
    m_k             = 0;
    m_shadow        = 8'h00;
    test_reset();
    test_enable();
    test_duty_half();
    test_duty_extremes();
    test_mid_period();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
Downstream consumer of the SPI register block. It takes the five SPI-written configuration registers and drives 16 output pins. Each pin is either forced low, forced high, or driven by a shared 8-bit PWM waveform. Duty-cycle changes are double-buffered and take effect only at a period boundary, so no glitched or truncated pulses appear on the pins.

Parameters:
PRESCALE_DIV, 3000, system clocks per PWM counter tick (must be >= 1; 1 = tick every clk)
PRESC_W, 12, width of prescaler counter (must hold PRESCALE_DIV-1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en_reg_out_7_0  in  8  output enable, pins 7..0
en_reg_out_15_8  in  8  output enable, pins 15..8
en_reg_pwm_7_0  in  8  PWM mode select, pins 7..0
en_reg_pwm_15_8  in  8  PWM mode select, pins 15..8
pwm_duty_cycle  in  8  requested duty (0x00 = 0%, 0xFF = 100%)
out  out  16  pin drive, registered
period_start  out  1  one-clk pulse at each PWM period boundary

Behaviour:
- Reset (async, rst=1) forces:
  - out=0, period_start=0
  - prescaler count=0, pwm_cnt=0, duty_shadow=0
- Release is synchronous to the next clk edge.
- Prescaler:
  - presc_cnt counts 0..PRESCALE_DIV-1 every clk, then wraps.
  - tick=1 for the single clk where presc_cnt==PRESCALE_DIV-1.
- PWM counter:
  - pwm_cnt (8 bit) increments on tick.
  - On tick with pwm_cnt==255, it wraps to 0 and, in the same edge:
    - duty_shadow <= pwm_duty_cycle
    - period_start <= 1 (0 at all other times)
  - Period = 256 ticks = 256*PRESCALE_DIV clks.
- Until the first boundary after reset, duty_shadow=0, so PWM-mode pins stay low for the first period.
- PWM level (combinational):
  - level = 1 if duty_shadow==0xFF
  - otherwise level = (pwm_cnt < duty_shadow)
  - Result: high time = duty*PRESCALE_DIV clks, except 0xFF = constant high and 0x00 = constant low.
- Pin mux, per bit i, with en_out = {en_reg_out_15_8, en_reg_out_7_0} and en_pwm likewise:
  - en_out[i]=0 → 0, regardless of en_pwm[i]
  - en_out[i]=1, en_pwm[i]=0 → 1
  - en_out[i]=1, en_pwm[i]=1 → level
- out is registered:
  - Enable/mode changes appear on out one clk after the input changes; they are not deferred to the boundary.
  - level changes appear one clk after pwm_cnt/duty_shadow change.
- Duty written mid-period: the current period completes with the old duty; the new value applies from the next period_start. Multiple writes in one period → the last value before the boundary wins.
- Duty written on the exact boundary clk: that value is captured.
- Inputs are assumed stable in the clk domain (the register block is synchronous to clk); no extra synchronisers.

Decomposition:
- Shared package pwm_pkg:
  - PWM_CNT_W=8
  - DUTY_FULL=8'hFF
  - NUM_PINS=16
- One sub-module: pwm_prescaler (parameterised divider producing the tick pulse). The counter, shadow register and pin mux stay in the top.

Test Plan:
All scenarios use PRESCALE_DIV=4.
- Reset, all regs 0 → out=0x0000, period_start pulses every 1024 clks.
- en_out=0x0001, en_pwm=0 → out=0x0001 exactly one clk after write; en_out=0x8000 → out=0x8000 next clk.
- duty=0x80, en_out=en_pwm=0x00FF → first period out=0x0000; after first period_start, out[7:0]=0xFF for 512 clks, then 0x00 for 512 clks, repeating.
- duty=0x00 → out[pwm pins] constant 0 across 3 periods; duty=0xFF → constant 1 with no 1-clk low blip at the wrap.
- duty 0x40 → 0xC0 written mid-period → current high time stays 256 clks; next period high 768 clks; write 0x10 then 0x20 in one period → 0x20 used.
- rst pulsed mid-high-phase → out=0 immediately (before next clk); after release, first period low, counters restart from 0.
